bin_counter_checker: RTL and testbench
======================================

// Module: bin_counter_checker
// PURPOSE
//  Synthesizable end-of-interface checker for the universal binary counter: observes the counter's
//  control inputs (syn_clr/load/en/up/d) and outputs (q/max_tick/min_tick), runs an internal expected
//  model, flags mismatches and counts errors. Sits beside the counter in benches and on-board self-test
//  builds; the consuming counterpart to the stimulus generator.
// PARAMETERS
//  N            3   counter width in bits (>=2)
//  ERR_W        8   width of error and check counters (saturating)
//  STOP_ON_ERR  0   1: freeze in FAIL after first mismatch; 0: keep checking
// PORTS
//  clk       in   1      system clock, all logic rising-edge
//  reset     in   1      synchronous, active-low (0 = reset); sampled on clk only
//  chk_en    in   1      1 = arm checking; 0 = model tracks but no compares
//  syn_clr   in   1      observed counter control
//  load      in   1      observed counter control
//  en        in   1      observed counter control
//  up        in   1      observed counter control (1 up, 0 down)
//  d         in   N      observed load data
//  q         in   N      observed counter value
//  max_tick  in   1      observed counter flag
//  min_tick  in   1      observed counter flag
//  err       out  1      one-cycle pulse, registered: mismatch detected on previous cycle
//  err_code  out  3      {tick_max_bad, tick_min_bad, q_bad} of last mismatch, sticky until reset
//  err_cnt   out  ERR_W  total mismatching cycles, saturates at all-ones
//  chk_cnt   out  ERR_W  total compared cycles, saturates at all-ones
//  fail      out  1      sticky: any mismatch since reset
// BEHAVIOUR
//  - reset=0 at edge: q_exp<=0, state<=IDLE, err/err_code/err_cnt/chk_cnt/fail <= 0.
//  - Model (next-state, same edge as counter): syn_clr -> 0; else load -> d; else en&up -> q_exp+1;
//    else en&~up -> q_exp-1; else hold. Priority syn_clr > load > en. Arithmetic mod 2**N (wraps).
//  - Expected flags from q_exp (combinational): max = (q_exp==2**N-1), min = (q_exp==0).
//  - Compare each cycle in CHECK: q vs q_exp, max_tick vs max, min_tick vs min; any bit differs ->
//    mismatch. Results registered: err/err_code/err_cnt/fail visible 1 cycle after the compared cycle.
//  - chk_cnt increments on every compared cycle; err_cnt on every mismatching cycle; both saturate.
//  - FSM: IDLE -(reset=1)-> SYNC; SYNC: one cycle, no compare, model already tracking from 0 -> CHECK
//    if chk_en else HOLD; HOLD: model tracks, no compare, -> CHECK when chk_en=1; CHECK -> HOLD when
//    chk_en=0; CHECK -> FAIL on mismatch iff STOP_ON_ERR=1. FAIL: no compares, counters frozen, model
//    still tracks; exits only by reset. reset=0 in any state -> IDLE on that edge.
//  - Simultaneous syn_clr+load+en: clear wins. Up at 2**N-1 -> 0; down at 0 -> 2**N-1 (no error).
//  - Mismatch does NOT resync q_exp to q (a stuck DUT keeps erroring).
// CONFIGURATION
//  - Macro BIN_CHK_COVER_EN defined: adds outputs cov_wrap_up, cov_wrap_dn, cov_load, cov_clr
//    (each ERR_W, saturating) counting model wrap-up (2**N-1->0 via en&up), wrap-down (0->2**N-1),
//    load and syn_clr events in HOLD/CHECK; reset to 0 with the rest.
//  - Not defined: those ports and counters do not exist; all other behaviour identical.
// STRUCTURE
//  - Package bin_chk_pkg: state encoding (IDLE, SYNC, HOLD, CHECK, FAIL), err_code bit indices
//    (ERR_Q=0, ERR_MIN=1, ERR_MAX=2), saturating-increment function.
//  - Sub-module bin_counter_model: N-bit expected counter (q_exp) + max/min derivation; top holds FSM,
//    compare, error/coverage counters.
// TESTING (N=3, ERR_W=8, STOP_ON_ERR=0 unless noted)
//  - Reset, chk_en=1, en=1 up=1, matching DUT for 10 cycles -> q_exp 0..7,0,1; err never 1; chk_cnt=9
//    (SYNC cycle not counted); max_tick expected at q=7 only.
//  - load=1 d=5 then en=1 up=0 x7 -> q_exp 5,4,..0,7,6; wrap-down without error; with COVER_EN cov_load=1,
//    cov_wrap_dn=1.
//  - syn_clr=1 load=1 en=1 d=6 same cycle -> q_exp=0; DUT q=6 injected -> err pulse next cycle,
//    err_code=3'b001, err_cnt=1, fail=1.
//  - Force min_tick=0 while q=0 -> err_code=3'b010; 300 forced mismatches -> err_cnt saturates at 255.
//  - STOP_ON_ERR=1, one bad q -> state FAIL; further mismatches leave err_cnt=1, chk_cnt frozen; reset=0
//    one cycle -> all outputs 0, state IDLE.
//  - chk_en=0 with DUT q wrong -> no err, chk_cnt unchanged; raise chk_en -> compares resume next cycle.

Source files
------------

// File: rtl/bin_chk_pkg.sv
// Shared types and helpers for bin_counter_checker.
// State encoding, err_code bit positions, saturating increment.
package bin_chk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        HOLD  = 3'd2,
        CHECK = 3'd3,
        FAIL  = 3'd4
    } chk_state_t;

    localparam int ERR_Q   = 0;
    localparam int ERR_MIN = 1;
    localparam int ERR_MAX = 2;

    // Counters up to 32 bits wide; caller truncates the result.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] top;
        top = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        return (v >= top) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/bin_counter_model.sv
// Expected-value model of the universal binary counter.
// Produces q_exp and the max/min flags it implies.
module bin_counter_model #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [N-1:0] d,
    output logic [N-1:0] q_exp,
    output logic         max_exp,
    output logic         min_exp
);

    localparam logic [N-1:0] ONE = N'(1);

    // Clear beats load beats count; arithmetic wraps mod 2**N.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_exp <= '0;
        end else begin
            priority case (1'b1)
                syn_clr:    q_exp <= '0;
                load:       q_exp <= d;
                (en && up): q_exp <= q_exp + ONE;
                en:         q_exp <= q_exp - ONE;
                default:    q_exp <= q_exp;
            endcase
        end
    end

    assign max_exp = (q_exp == '1);
    assign min_exp = (q_exp == '0);

endmodule

// File: rtl/bin_counter_checker.sv
// End-of-interface checker for the universal binary counter.
// Define BIN_CHK_COVER_EN to add the cov_* event counters.
module bin_counter_checker
    import bin_chk_pkg::*;
#(
    parameter int N           = 3,
    parameter int ERR_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chk_en,
    input  logic             syn_clr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [N-1:0]     d,
    input  logic [N-1:0]     q,
    input  logic             max_tick,
    input  logic             min_tick,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] chk_cnt,
    output logic             fail
`ifdef BIN_CHK_COVER_EN
    ,
    output logic [ERR_W-1:0] cov_wrap_up,
    output logic [ERR_W-1:0] cov_wrap_dn,
    output logic [ERR_W-1:0] cov_load,
    output logic [ERR_W-1:0] cov_clr
`endif
);

    chk_state_t   state_q;
    chk_state_t   state_d;
    logic [N-1:0] q_exp;
    logic         max_exp;
    logic         min_exp;
    logic [2:0]   bad_bits;
    logic         do_cmp;
    logic         do_cov;
    logic         mismatch;

    bin_counter_model #(.N(N)) u_model (
        .clk     (clk),
        .reset   (reset),
        .syn_clr (syn_clr),
        .load    (load),
        .en      (en),
        .up      (up),
        .d       (d),
        .q_exp   (q_exp),
        .max_exp (max_exp),
        .min_exp (min_exp)
    );

    always_comb begin
        bad_bits          = '0;
        bad_bits[ERR_Q]   = (q != q_exp);
        bad_bits[ERR_MIN] = (min_tick != min_exp);
        bad_bits[ERR_MAX] = (max_tick != max_exp);
    end

    assign mismatch = do_cmp && (|bad_bits);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = SYNC;
            SYNC:  state_d = chk_en ? CHECK : HOLD;
            HOLD:  state_d = chk_en ? CHECK : HOLD;
            CHECK: begin
                if (STOP_ON_ERR && mismatch) state_d = FAIL;
                else if (!chk_en)            state_d = HOLD;
                else                         state_d = CHECK;
            end
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        do_cmp = (state_q == CHECK);
        do_cov = (state_q == CHECK) || (state_q == HOLD);
    end

    // A mismatch never resyncs the model, so a stuck counter keeps erroring.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err      <= 1'b0;
            err_code <= '0;
            err_cnt  <= '0;
            chk_cnt  <= '0;
            fail     <= 1'b0;
        end else begin
            err <= mismatch;
            if (mismatch) begin
                err_code <= bad_bits;
                err_cnt  <= ERR_W'(sat_inc(32'(err_cnt), ERR_W));
                fail     <= 1'b1;
            end
            if (do_cmp) begin
                chk_cnt <= ERR_W'(sat_inc(32'(chk_cnt), ERR_W));
            end
        end
    end

`ifdef BIN_CHK_COVER_EN
    logic ev_up;
    logic ev_dn;
    logic ev_ld;
    logic ev_clr;

    assign ev_up  = do_cov && !syn_clr && !load && en && up && max_exp;
    assign ev_dn  = do_cov && !syn_clr && !load && en && !up && min_exp;
    assign ev_ld  = do_cov && !syn_clr && load;
    assign ev_clr = do_cov && syn_clr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cov_wrap_up <= '0;
            cov_wrap_dn <= '0;
            cov_load    <= '0;
            cov_clr     <= '0;
        end else begin
            if (ev_up)
                cov_wrap_up <= ERR_W'(sat_inc(32'(cov_wrap_up), ERR_W));
            if (ev_dn)
                cov_wrap_dn <= ERR_W'(sat_inc(32'(cov_wrap_dn), ERR_W));
            if (ev_ld)
                cov_load <= ERR_W'(sat_inc(32'(cov_load), ERR_W));
            if (ev_clr)
                cov_clr <= ERR_W'(sat_inc(32'(cov_clr), ERR_W));
        end
    end
`endif

endmodule

// File: tb/tb_bin_counter_checker.sv
// Bench for bin_counter_checker: two instances (STOP_ON_ERR 0/1)
// against an arithmetic reference of the counter and checker rules.
module tb_bin_counter_checker;

    localparam int N    = 3;
    localparam int W    = 8;
    localparam int QMAX = 7;
    localparam int SAT  = 255;

    logic       clk = 1'b0;
    logic       reset, chk_en, syn_clr, load, en, up;
    logic       max_tick, min_tick;
    logic [2:0] d, q;

    logic       err0, err1, fail0, fail1;
    logic [2:0] code0, code1;
    logic [7:0] ecnt0, ecnt1, ccnt0, ccnt1;
`ifdef BIN_CHK_COVER_EN
    logic [7:0] cu0, cd0, cl0, cc0, cu1, cd1, cl1, cc1;
`endif

    always #5 clk = ~clk;

    bin_counter_checker #(.N(N), .ERR_W(W), .STOP_ON_ERR(1'b0)) u_chk0 (
        .clk(clk), .reset(reset), .chk_en(chk_en),
        .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
        .q(q), .max_tick(max_tick), .min_tick(min_tick),
        .err(err0), .err_code(code0), .err_cnt(ecnt0),
        .chk_cnt(ccnt0), .fail(fail0)
`ifdef BIN_CHK_COVER_EN
        , .cov_wrap_up(cu0), .cov_wrap_dn(cd0)
        , .cov_load(cl0), .cov_clr(cc0)
`endif
    );

    bin_counter_checker #(.N(N), .ERR_W(W), .STOP_ON_ERR(1'b1)) u_chk1 (
        .clk(clk), .reset(reset), .chk_en(chk_en),
        .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d),
        .q(q), .max_tick(max_tick), .min_tick(min_tick),
        .err(err1), .err_code(code1), .err_cnt(ecnt1),
        .chk_cnt(ccnt1), .fail(fail1)
`ifdef BIN_CHK_COVER_EN
        , .cov_wrap_up(cu1), .cov_wrap_dn(cd1)
        , .cov_load(cl1), .cov_clr(cc1)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: counter value plus per-instance checker expectations.
    int ref_q = 0;
    bit m_err[2];
    int m_code[2];
    int m_ecnt[2];
    int m_ccnt[2];
    bit m_fail[2];
    int m_age[2];   // 0 just reset, 1 first cycle after, 2 running
    bit m_on[2];    // comparing this cycle
    bit m_frz[2];   // stopped after first error
    int c_up[2], c_dn[2], c_ld[2], c_clr[2];

    function automatic int sat(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    task automatic model_edge();
        int  bits;
        bit  mis;
        bit  win;
        bits = 0;
        if (int'(q) != ref_q)              bits |= 1;
        if (min_tick != (ref_q == 0))      bits |= 2;
        if (max_tick != (ref_q == QMAX))   bits |= 4;
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_err[k] = 0; m_code[k] = 0; m_ecnt[k] = 0;
                m_ccnt[k] = 0; m_fail[k] = 0; m_age[k] = 0;
                m_on[k] = 0; m_frz[k] = 0;
                c_up[k] = 0; c_dn[k] = 0; c_ld[k] = 0; c_clr[k] = 0;
            end else begin
                win = (m_age[k] == 2) && !m_frz[k];
                if (win && !syn_clr && !load && en && up && ref_q == QMAX)
                    c_up[k] = sat(c_up[k]);
                if (win && !syn_clr && !load && en && !up && ref_q == 0)
                    c_dn[k] = sat(c_dn[k]);
                if (win && !syn_clr && load) c_ld[k] = sat(c_ld[k]);
                if (win && syn_clr)          c_clr[k] = sat(c_clr[k]);
                mis = m_on[k] && (bits != 0);
                m_err[k] = mis;
                if (mis) begin
                    m_code[k] = bits;
                    m_ecnt[k] = sat(m_ecnt[k]);
                    m_fail[k] = 1;
                end
                if (m_on[k]) m_ccnt[k] = sat(m_ccnt[k]);
                if (m_age[k] == 0)        m_on[k] = 0;
                else if (m_frz[k])        m_on[k] = 0;
                else if (k == 1 && mis) begin
                    m_frz[k] = 1;
                    m_on[k]  = 0;
                end else                  m_on[k] = chk_en;
                if (m_age[k] < 2) m_age[k]++;
            end
        end
        if (!reset)        ref_q = 0;
        else if (syn_clr)  ref_q = 0;
        else if (load)     ref_q = int'(d);
        else if (en && up) ref_q = (ref_q + 1) % 8;
        else if (en)       ref_q = (ref_q + 7) % 8;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("err0",  32'(err0),  m_err[0]);
        check("code0", 32'(code0), m_code[0]);
        check("ecnt0", 32'(ecnt0), m_ecnt[0]);
        check("ccnt0", 32'(ccnt0), m_ccnt[0]);
        check("fail0", 32'(fail0), m_fail[0]);
        check("err1",  32'(err1),  m_err[1]);
        check("code1", 32'(code1), m_code[1]);
        check("ecnt1", 32'(ecnt1), m_ecnt[1]);
        check("ccnt1", 32'(ccnt1), m_ccnt[1]);
        check("fail1", 32'(fail1), m_fail[1]);
`ifdef BIN_CHK_COVER_EN
        check("cu0", 32'(cu0), c_up[0]);
        check("cd0", 32'(cd0), c_dn[0]);
        check("cl0", 32'(cl0), c_ld[0]);
        check("cc0", 32'(cc0), c_clr[0]);
        check("cu1", 32'(cu1), c_up[1]);
        check("cd1", 32'(cd1), c_dn[1]);
        check("cl1", 32'(cl1), c_ld[1]);
        check("cc1", 32'(cc1), c_clr[1]);
`endif
    endtask

    // Emulates a counter showing ref_q, with optional corruption.
    task automatic drive(input bit rs, input bit ce, input bit sc,
                         input bit ld, input bit e, input bit u,
                         input int dd, input int qx,
                         input bit mf, input bit nf);
        logic [2:0] qv;
        reset    = rs;
        chk_en   = ce;
        syn_clr  = sc;
        load     = ld;
        en       = e;
        up       = u;
        d        = 3'(dd);
        qv       = 3'(ref_q ^ qx);
        q        = qv;
        max_tick = (ref_q == QMAX) ^ mf;
        min_tick = (ref_q == 0) ^ nf;
        cycle();
    endtask

    initial begin
        reset = 0; chk_en = 0; syn_clr = 0; load = 0; en = 0; up = 0;
        d = '0; q = '0; max_tick = 0; min_tick = 1;
        @(negedge clk);

        repeat (2) drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_err",  32'(err0),  0);
        check("rst_code", 32'(code0), 0);
        check("rst_ecnt", 32'(ecnt0), 0);
        check("rst_ccnt", 32'(ccnt0), 0);
        check("rst_fail", 32'(fail0), 0);

        // Count up 0..7,0,1 with a matching counter.
        drive(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (10) drive(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        check("up_ccnt", 32'(ccnt0), 9);
        check("up_ecnt", 32'(ecnt0), 0);

        // Load 5 then count down through the wrap.
        drive(1, 1, 0, 1, 0, 0, 5, 0, 0, 0);
        repeat (7) drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        check("dn_ecnt", 32'(ecnt0), 0);
        check("dn_fail", 32'(fail0), 0);
`ifdef BIN_CHK_COVER_EN
        check("dn_cov_load", 32'(cl0), 1);
        check("dn_cov_wdn",  32'(cd0), 1);
        check("dn_cov_wup",  32'(cu0), 1);
`endif

        // Clear wins over load; counter shows the loaded 6.
        drive(1, 1, 1, 1, 1, 1, 6, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 6, 0, 0);
        check("clr_err",   32'(err0),  1);
        check("clr_code",  32'(code0), 1);
        check("clr_ecnt",  32'(ecnt0), 1);
        check("clr_fail",  32'(fail0), 1);
        check("stop_fail", 32'(fail1), 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("err_pulse", 32'(err0), 0);

        // min_tick stuck low at q=0, then saturate.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("min_code", 32'(code0), 2);
        repeat (300) drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("sat_ecnt",  32'(ecnt0), 255);
        check("sat_ccnt",  32'(ccnt0), 255);
        check("stop_ecnt", 32'(ecnt1), 1);
        check("stop_ccnt", 32'(ccnt1), 19);
        check("stop_err",  32'(err1),  0);

        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst2_fail1", 32'(fail1), 0);
        check("rst2_ecnt1", 32'(ecnt1), 0);
        check("rst2_ccnt1", 32'(ccnt1), 0);
        check("rst2_code1", 32'(code1), 0);
        check("rst2_ecnt0", 32'(ecnt0), 0);

        // chk_en low hides a wrong q; compares resume a cycle after raising.
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        repeat (4) drive(1, 0, 0, 0, 1, 1, 0, 3, 0, 0);
        check("hold_ecnt", 32'(ecnt0), 0);
        check("hold_ccnt", 32'(ccnt0), 3);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        check("resume_err",  32'(err0),  1);
        check("resume_ecnt", 32'(ecnt0), 1);
        check("resume_ccnt", 32'(ccnt0), 4);

        // Randomised traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            bit rs, ce, inj;
            int qx;
            rs  = ($urandom_range(99) != 0);
            ce  = ($urandom_range(9) != 0);
            inj = ($urandom_range(19) == 0);
            qx  = inj ? int'($urandom_range(7)) : 0;
            drive(rs, ce,
                  $urandom_range(15) == 0,
                  $urandom_range(7) == 0,
                  $urandom_range(3) != 0,
                  1'($urandom_range(1)),
                  int'($urandom_range(7)), qx,
                  inj && ($urandom_range(3) == 0),
                  inj && ($urandom_range(3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
